traffic_intersection_ctrl: RTL

//  Timed two-approach (NS/EW) intersection controller; successor to the fixed 3-state light.

---
 rtl/tl_pkg.sv | 37 +++
 rtl/tl_phase_timer.sv | 40 ++++
 rtl/traffic_intersection_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared definitions for the NS/EW intersection controller: phase encoding,
// lamp patterns and the per-phase duration lookup.
package tl_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        PED_WALK  = 3'd6
    } tl_state_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Value the phase timer is loaded with on entry to a phase (duration minus one).
    function automatic int unsigned phase_dur_m1(
        input tl_state_e   s,
        input int unsigned green,
        input int unsigned yellow,
        input int unsigned allred,
        input int unsigned walk
    );
        int unsigned d;
        case (s)
            NS_GREEN, EW_GREEN:   d = green;
            NS_YELLOW, EW_YELLOW: d = yellow;
            PED_WALK:             d = walk;
            default:              d = allred;
        endcase
        return d - 1;
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase down-counter: reloads on load, freezes on hold, otherwise counts down
// and rests at zero; done flags the last cycle of the current phase.
module tl_phase_timer #(
    parameter int               CNT_W     = 8,
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    // A load always wins so an illegal-state recovery cannot be blocked by hold.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (!hold && count_q != '0) begin
            count_d = count_q - ONE;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Timed two-approach intersection controller with all-red clearance and hold.
// Define TL_PED_WALK_EN to add the pedestrian walk phase after ALLRED_B.
module traffic_intersection_ctrl
    import tl_pkg::*;
#(
    parameter int unsigned GREEN_CYCLES  = 8,
    parameter int unsigned YELLOW_CYCLES = 2,
    parameter int unsigned ALLRED_CYCLES = 1,
    parameter int unsigned WALK_CYCLES   = 4,
    parameter int          CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic       ped_req,
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp,
    output logic       walk,
    output logic       phase_end
);

    localparam logic [CNT_W-1:0] TIMER_RESET = CNT_W'(ALLRED_CYCLES - 1);

    tl_state_e        state_q;
    tl_state_e        state_d;
    logic             timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic             timer_done;
    logic             advance;

    tl_phase_timer #(
        .CNT_W    (CNT_W),
        .RESET_VAL(TIMER_RESET)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .load_val(timer_load_val),
        .hold    (hold),
        .done    (timer_done)
    );

    assign advance = timer_done && !hold;

`ifdef TL_PED_WALK_EN
    logic ped_pending_q;
    logic ped_pending_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_pending_q <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
        end
    end

    // Entering the walk phase consumes the request; a same-cycle ped_req is dropped.
    always_comb begin
        ped_pending_d = ped_pending_q | ped_req;
        if (state_q == ALLRED_B && state_d == PED_WALK) begin
            ped_pending_d = 1'b0;
        end
    end
`else
    logic ped_req_unused;
    assign ped_req_unused = ped_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ALLRED_B;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        case (state_q)
            NS_GREEN: if (advance) begin state_d = NS_YELLOW; timer_load = 1'b1; end
            NS_YELLOW: if (advance) begin state_d = ALLRED_A; timer_load = 1'b1; end
            ALLRED_A: if (advance) begin state_d = EW_GREEN; timer_load = 1'b1; end
            EW_GREEN: if (advance) begin state_d = EW_YELLOW; timer_load = 1'b1; end
            EW_YELLOW: if (advance) begin state_d = ALLRED_B; timer_load = 1'b1; end
            ALLRED_B: begin
                if (advance) begin
`ifdef TL_PED_WALK_EN
                    state_d = ped_pending_q ? PED_WALK : NS_GREEN;
`else
                    state_d = NS_GREEN;
`endif
                    timer_load = 1'b1;
                end
            end
`ifdef TL_PED_WALK_EN
            PED_WALK: if (advance) begin state_d = NS_GREEN; timer_load = 1'b1; end
`endif
            // Any unreachable encoding falls back to clearance, regardless of hold.
            default: begin
                state_d    = ALLRED_B;
                timer_load = 1'b1;
            end
        endcase
    end

    assign timer_load_val = CNT_W'(phase_dur_m1(state_d, GREEN_CYCLES, YELLOW_CYCLES,
                                                 ALLRED_CYCLES, WALK_CYCLES));

    always_comb begin
        ns_lamp = LAMP_RED;
        ew_lamp = LAMP_RED;
        walk    = 1'b0;
        case (state_q)
            NS_GREEN:  ns_lamp = LAMP_GRN;
            NS_YELLOW: ns_lamp = LAMP_YEL;
            EW_GREEN:  ew_lamp = LAMP_GRN;
            EW_YELLOW: ew_lamp = LAMP_YEL;
`ifdef TL_PED_WALK_EN
            PED_WALK:  walk    = 1'b1;
`endif
            default: begin
                ns_lamp = LAMP_RED;
                ew_lamp = LAMP_RED;
            end
        endcase
    end

    assign phase_end = advance && !reset;

endmodule
